wb_stage: RTL

MEM/WB pipeline register and write-back selector for the MIPS pipeline. Captures the MEM-stage result each cycle and drives the register-file write port (`write`, `wrAddr`, `wrData`) one cycle later. Performs load byte/halfword extraction with sign/zero extension and suppresses writes to $0. Exports the same write triple as a bypass source for the EX-stage forwarding unit.

---
 rtl/wb_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : MEM/WB pipeline register and write-back selector. Handles load
//            extraction, $0 suppression and misaligned-load detection.
//            Optional retire counter enabled by macro WB_RETIRE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic        mem_mem_to_reg,
    input  logic [1:0]  mem_load_size,
    input  logic        mem_load_signed,
    input  logic [1:0]  mem_byte_off,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_load_data,
    output logic        write,
    output logic [4:0]  wrAddr,
    output logic [31:0] wrData,
    output logic        err_misalign,
    output logic [31:0] retire_cnt
);

    localparam logic [1:0] c_SIZE_WORD = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_BYTE = 2'b10;

    logic        r_valid;
    logic        r_fresh;
    logic        r_regWrite;
    logic        r_memToReg;
    logic [1:0]  r_loadSize;
    logic        r_loadSigned;
    logic [1:0]  r_byteOff;
    logic [4:0]  r_dest;
    logic [31:0] r_aluResult;
    logic [31:0] r_loadData;

    logic        w_live;
    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_wrData;

    // Flush only kills the entry; the captured fields are don't-care once invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_fresh      <= 1'b0;
            r_regWrite   <= 1'b0;
            r_memToReg   <= 1'b0;
            r_loadSize   <= 2'b00;
            r_loadSigned <= 1'b0;
            r_byteOff    <= 2'b00;
            r_dest       <= 5'd0;
            r_aluResult  <= 32'd0;
            r_loadData   <= 32'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_fresh <= 1'b0;
        end else if (stall) begin
            r_fresh <= 1'b0;
        end else begin
            r_valid      <= mem_valid;
            r_fresh      <= mem_valid;
            r_regWrite   <= mem_reg_write;
            r_memToReg   <= mem_mem_to_reg;
            r_loadSize   <= mem_load_size;
            r_loadSigned <= mem_load_signed;
            r_byteOff    <= mem_byte_off;
            r_dest       <= mem_dest;
            r_aluResult  <= mem_alu_result;
            r_loadData   <= mem_load_data;
        end
    end

    // An entry acts only in the first cycle after capture, so a stalled entry never rewrites.
    assign w_live = r_valid & r_fresh;

    always_comb begin
        w_misalign = 1'b0;
        if (w_live && r_memToReg) begin
            case (r_loadSize)
                c_SIZE_HALF: w_misalign = r_byteOff[0];
                c_SIZE_BYTE: w_misalign = 1'b0;
                default:     w_misalign = (r_byteOff != 2'b00);
            endcase
        end
    end

    always_comb begin
        w_byte   = 8'h00;
        w_half   = r_byteOff[1] ? r_loadData[31:16] : r_loadData[15:0];
        w_wrData = r_aluResult;
        case (r_byteOff)
            2'd0:    w_byte = r_loadData[7:0];
            2'd1:    w_byte = r_loadData[15:8];
            2'd2:    w_byte = r_loadData[23:16];
            default: w_byte = r_loadData[31:24];
        endcase
        if (r_memToReg) begin
            case (r_loadSize)
                c_SIZE_HALF: w_wrData = {{16{r_loadSigned & w_half[15]}}, w_half};
                c_SIZE_BYTE: w_wrData = {{24{r_loadSigned & w_byte[7]}}, w_byte};
                c_SIZE_WORD: w_wrData = r_loadData;
                default:     w_wrData = r_loadData;
            endcase
        end
    end

    assign write        = w_live & r_regWrite & (r_dest != 5'd0) & ~w_misalign;
    assign wrAddr       = r_dest;
    assign wrData       = w_wrData;
    assign err_misalign = w_misalign;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retireCnt;
    logic        w_retire;

    assign w_retire = w_live & ~w_misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retireCnt <= 32'd0;
        end else if (w_retire) begin
            r_retireCnt <= r_retireCnt + 32'd1;
        end
    end

    assign retire_cnt = r_retireCnt;
`else
    assign retire_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
